// File: rtl/image_sender.sv
// rtl/image_sender.sv - streams an image buffer from RAM to the UART transmitter followed by a two-byte end marker
module image_sender #(
    parameter int          IMG_SIZE = 784,
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  END1     = 8'h66,
    parameter logic [7:0]  END2     = 8'hBB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] debug_tx_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

    // Phase encoding: which part of the frame the byte in flight belongs to.
    localparam logic [1:0] PH_PAYLOAD = 2'd0;
    localparam logic [1:0] PH_END1    = 2'd1;
    localparam logic [1:0] PH_END2    = 2'd2;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] byte_count;
    logic [1:0]        phase;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; strobes come straight from the registered
    // state so they are all 0 the moment reset asserts.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        tx_start   = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                rd_en      = 1'b1;
                rd_addr    = byte_count;
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                // A UART still busy from another user simply stalls us here.
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (phase == PH_END2) begin
                        state_next = ST_DONE;
                    end else if (phase == PH_PAYLOAD && byte_count != LAST_ADDR) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: byte counter, marker phase, outgoing byte, busy flag and
    // the saturating count of issued bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count     <= '0;
            phase          <= PH_PAYLOAD;
            tx_data        <= '0;
            busy           <= 1'b0;
            debug_tx_count <= '0;
        end else begin
            if (tx_start && debug_tx_count != '1) begin
                debug_tx_count <= debug_tx_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        byte_count     <= '0;
                        phase          <= PH_PAYLOAD;
                        debug_tx_count <= '0;
                        busy           <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    tx_data <= rd_data;
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (phase == PH_PAYLOAD) begin
                            if (byte_count != LAST_ADDR) begin
                                byte_count <= byte_count + 1'b1;
                            end else begin
                                phase   <= PH_END1;
                                tx_data <= END1;
                            end
                        end else if (phase == PH_END1) begin
                            phase   <= PH_END2;
                            tx_data <= END2;
                        end
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_sender.sv
// tb/tb_image_sender.sv - self-checking bench for image_sender
module tb_image_sender;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       hold;
    logic       rd_en;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       done;
    logic [9:0] dbg;
    int         ucnt;

    logic       s_start;
    logic       s_rd_en;
    logic [9:0] s_rd_addr;
    logic [7:0] s_rd_data;
    logic [7:0] s_tx_data;
    logic       s_tx_start;
    logic       s_tx_busy;
    logic       s_busy;
    logic       s_done;
    logic [9:0] s_dbg;
    int         s_ucnt;
    logic [3:0][7:0] s_ram;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0, rd_seen = 0, done_seen = 0, rd_next = 0;
    int s_tx_seen = 0, s_rd_seen = 0, s_done_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] s_q[$];

    image_sender dut (
        .clk(clk), .rst(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .done(done), .debug_tx_count(dbg)
    );

    image_sender #(.IMG_SIZE(4)) dut_s (
        .clk(clk), .rst(rst_n), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .tx_data(s_tx_data), .tx_start(s_tx_start), .tx_busy(s_tx_busy),
        .busy(s_busy), .done(s_done), .debug_tx_count(s_dbg)
    );

    // UART models: busy rises the cycle after tx_start and lasts 10 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ucnt <= 0;
        else if (tx_start) ucnt <= 10;
        else if (ucnt != 0) ucnt <= ucnt - 1;
    end
    assign tx_busy = (ucnt != 0) || hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ucnt <= 0;
        else if (s_tx_start) s_ucnt <= 10;
        else if (s_ucnt != 0) s_ucnt <= s_ucnt - 1;
    end
    assign s_tx_busy = (s_ucnt != 0);

    // RAM models with one cycle read latency.
    always @(posedge clk) rd_data <= rd_addr[7:0];
    always @(posedge clk) s_rd_data <= s_ram[s_rd_addr[1:0]];

    function automatic void chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endfunction

    // Scoreboard monitors: pop expected bytes on every tx_start.
    always @(negedge clk) begin
        if (tx_start) begin
            tx_seen++;
            if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_byte", tx_data, exp_q.pop_front());
        end
        if (rd_en) begin
            rd_seen++;
            chk("rd_addr", rd_addr, rd_next);
            rd_next++;
        end
        if (done) done_seen++;
        if (s_tx_start) begin
            s_tx_seen++;
            if (s_q.size() == 0) chk("s_tx_unexpected", 1, 0);
            else chk("s_tx_byte", s_tx_data, s_q.pop_front());
        end
        if (s_rd_en) begin
            chk("s_rd_addr", s_rd_addr, s_rd_seen % 4);
            s_rd_seen++;
        end
        if (s_done) s_done_seen++;
    end

    task automatic push_big();
        for (int i = 0; i < 784; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h66);
        exp_q.push_back(8'hBB);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_big_done(input int budget);
        int n = 0;
        while (n < budget) begin
            @(posedge clk); #2;
            if (done) break;
            n++;
        end
        if (n >= budget) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_small_done(input int budget);
        int n = 0;
        while (n < budget) begin
            @(posedge clk); #2;
            if (s_done) break;
            n++;
        end
        if (n >= budget) chk("s_done_timeout", 0, 1);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_seen < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) chk("tx_count_timeout", tx_seen, target);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dbg"}, dbg, 0);
    endtask

    typedef struct {
        logic [3:0][7:0] ram;
        int              frames;
        int              exp_done;
        int              exp_rd;
        int              exp_dbg;
    } vec_t;

    initial begin
        vec_t vecs[2];
        int t0, d0, r0, t1;
        vecs[0] = '{ram: 32'hBB66BB66, frames: 2, exp_done: 2, exp_rd: 8, exp_dbg: 6};
        vecs[1] = '{ram: 32'hFFBB6600, frames: 1, exp_done: 1, exp_rd: 4, exp_dbg: 6};

        rst_n = 1'b0; start = 1'b0; hold = 1'b0; s_start = 1'b0; s_ram = '0;
        @(posedge clk); #2;
        check_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // Full frame whose first byte is blocked by a busy UART.
        push_big(); rd_next = 0;
        hold = 1'b1;
        pulse_start();
        repeat (50) @(posedge clk);
        #2;
        chk("blocked_no_tx", tx_seen, 0);
        chk("blocked_busy", busy, 1);
        hold = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("released_tx", tx_seen, 1);
        wait_big_done(20000);
        @(posedge clk); #2;
        chk("f1_done", done_seen, 1);
        chk("f1_busy", busy, 0);
        chk("f1_dbg", dbg, 786);
        chk("f1_tx", tx_seen, 786);
        chk("f1_rd", rd_seen, 784);
        chk("f1_queue", exp_q.size(), 0);

        // Starts during the frame and in the done cycle are ignored.
        t0 = tx_seen; d0 = done_seen;
        push_big(); rd_next = 0;
        pulse_start();
        wait_tx(t0 + 5, 200);
        pulse_start();
        wait_big_done(20000);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("f2_tx", tx_seen - t0, 786);
        chk("f2_done", done_seen - d0, 1);
        chk("f2_idle_busy", busy, 0);
        chk("f2_queue", exp_q.size(), 0);

        // Reset after byte 100 aborts the frame.
        t0 = tx_seen;
        push_big(); rd_next = 0;
        pulse_start();
        wait_tx(t0 + 101, 3000);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk); #2 rst_n = 1'b1;
        exp_q.delete();
        t1 = tx_seen;
        repeat (40) @(posedge clk);
        #2;
        chk("no_tx_after_reset", tx_seen, t1);

        // Fresh frame after the abort starts again at address 0.
        t0 = tx_seen; d0 = done_seen; r0 = rd_seen;
        push_big(); rd_next = 0;
        pulse_start();
        wait_big_done(20000);
        @(posedge clk); #2;
        chk("f4_tx", tx_seen - t0, 786);
        chk("f4_rd", rd_seen - r0, 784);
        chk("f4_done", done_seen - d0, 1);
        chk("f4_dbg", dbg, 12'h312);
        chk("f4_queue", exp_q.size(), 0);

        // Small image, including payload equal to the marker bytes.
        for (int v = 0; v < 2; v++) begin
            d0 = s_done_seen; r0 = s_rd_seen;
            s_ram = vecs[v].ram;
            for (int f = 0; f < vecs[v].frames; f++) begin
                for (int b = 0; b < 4; b++) s_q.push_back(vecs[v].ram[b]);
                s_q.push_back(8'h66);
                s_q.push_back(8'hBB);
            end
            @(posedge clk); #2 s_start = 1'b1;
            @(posedge clk); #2 s_start = 1'b0;
            for (int f = 0; f < vecs[v].frames; f++) begin
                wait_small_done(500);
                if (f < vecs[v].frames - 1) begin
                    @(posedge clk); #2 s_start = 1'b1;
                    @(posedge clk); #2 s_start = 1'b0;
                end
            end
            repeat (5) @(posedge clk);
            #2;
            chk("s_done", s_done_seen - d0, vecs[v].exp_done);
            chk("s_rd", s_rd_seen - r0, vecs[v].exp_rd);
            chk("s_dbg", s_dbg, vecs[v].exp_dbg);
            chk("s_busy", s_busy, 0);
            chk("s_queue", s_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
